usb_tx_encoder: RTL and testbench



---
 rtl/usb_tx_encoder.sv | 214 +++++++++++++++++++++
 tb/tb_usb_tx_encoder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_encoder.sv
// USB full-speed transmit line encoder: SYNC, NRZI with bit stuffing (LSB first), EOP, idle J.
// Define USB_TX_ABORT_EN to add tx_abort (7-bit stuff-violation abort followed by a normal EOP).
module usb_tx_encoder #(
    parameter int CLKS_PER_BIT = 8
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
`ifdef USB_TX_ABORT_EN
    input  logic       tx_abort,
`endif
    output logic       tx_byte_ack,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       d_plus,
    output logic       d_minus
);

    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0] TMAX = TW'(CLKS_PER_BIT - 1);

`ifdef USB_TX_ABORT_EN
    typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J, ABORT} state_t;
`else
    typedef enum logic [2:0] {IDLE, SYNC, DATA, STUFF, EOP_SE0, EOP_J} state_t;
`endif

    state_t          state, state_n;
    logic [TW-1:0]   timer, timer_n;
    logic [2:0]      bit_idx, bit_idx_n;
    logic [2:0]      ones, ones_n;
    logic [7:0]      shreg, shreg_n;
    logic            dp_n, dm_n, busy_n, done_n;
    logic            boundary, byte_end, emit_en, emit_bit;
    logic [2:0]      nxt_idx;

    assign boundary = (timer == TMAX);
    assign nxt_idx  = bit_idx + 3'd1;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state   <= IDLE;
            timer   <= '0;
            bit_idx <= '0;
            ones    <= '0;
            shreg   <= '0;
            d_plus  <= 1'b1;
            d_minus <= 1'b0;
            tx_busy <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            state   <= state_n;
            timer   <= timer_n;
            bit_idx <= bit_idx_n;
            ones    <= ones_n;
            shreg   <= shreg_n;
            d_plus  <= dp_n;
            d_minus <= dm_n;
            tx_busy <= busy_n;
            tx_done <= done_n;
        end
    end

    always_comb begin
        state_n     = state;
        timer_n     = timer;
        bit_idx_n   = bit_idx;
        ones_n      = ones;
        shreg_n     = shreg;
        dp_n        = d_plus;
        dm_n        = d_minus;
        busy_n      = tx_busy;
        done_n      = 1'b0;
        tx_byte_ack = 1'b0;
        byte_end    = 1'b0;
        emit_en     = 1'b0;
        emit_bit    = 1'b0;

        if (state != IDLE)
            timer_n = boundary ? '0 : timer + 1'b1;

        case (state)
            IDLE: begin
                // A start coinciding with the done pulse belongs to the old packet and is dropped.
                if (tx_start && !tx_done) begin
                    state_n   = SYNC;
                    timer_n   = '0;
                    bit_idx_n = '0;
                    ones_n    = '0;
                    busy_n    = 1'b1;
                    emit_en   = 1'b1;
                    emit_bit  = 1'b0;
                end
            end
            SYNC: begin
                if (boundary) begin
                    if (bit_idx == 3'd7) begin
                        byte_end = 1'b1;
                    end else begin
                        bit_idx_n = nxt_idx;
                        emit_en   = 1'b1;
                        emit_bit  = (bit_idx == 3'd6);
                    end
                end
            end
            DATA: begin
                if (boundary) begin
                    if (ones == 3'd6) begin
                        // Stuff bit holds bit_idx so the byte-end test still sees bit 7.
                        state_n  = STUFF;
                        emit_en  = 1'b1;
                        emit_bit = 1'b0;
                    end else if (bit_idx == 3'd7) begin
                        byte_end = 1'b1;
                    end else begin
                        bit_idx_n = nxt_idx;
                        emit_en   = 1'b1;
                        emit_bit  = shreg[nxt_idx];
                    end
                end
            end
            STUFF: begin
                if (boundary) begin
                    if (bit_idx == 3'd7) begin
                        byte_end = 1'b1;
                    end else begin
                        state_n   = DATA;
                        bit_idx_n = nxt_idx;
                        emit_en   = 1'b1;
                        emit_bit  = shreg[nxt_idx];
                    end
                end
            end
            EOP_SE0: begin
                if (boundary) begin
                    if (bit_idx == 3'd1) begin
                        state_n   = EOP_J;
                        bit_idx_n = '0;
                        dp_n      = 1'b1;
                        dm_n      = 1'b0;
                    end else begin
                        bit_idx_n = nxt_idx;
                    end
                end
            end
            EOP_J: begin
                if (boundary) begin
                    state_n   = IDLE;
                    timer_n   = '0;
                    bit_idx_n = '0;
                    ones_n    = '0;
                    busy_n    = 1'b0;
                    done_n    = 1'b1;
                end
            end
`ifdef USB_TX_ABORT_EN
            ABORT: begin
                if (boundary) begin
                    if (bit_idx == 3'd6) begin
                        state_n   = EOP_SE0;
                        bit_idx_n = '0;
                        dp_n      = 1'b0;
                        dm_n      = 1'b0;
                    end else begin
                        bit_idx_n = nxt_idx;
                    end
                end
            end
`endif
            default: state_n = IDLE;
        endcase

`ifdef USB_TX_ABORT_EN
        // Abort wins over any byte load or stuff decision made at the same boundary.
        if (boundary && tx_abort && (state == SYNC || state == DATA || state == STUFF)) begin
            state_n   = ABORT;
            bit_idx_n = '0;
            ones_n    = '0;
            byte_end  = 1'b0;
            emit_en   = 1'b0;
        end
`endif

        if (byte_end) begin
            bit_idx_n = '0;
            if (tx_data_valid) begin
                tx_byte_ack = 1'b1;
                shreg_n     = tx_data;
                state_n     = DATA;
                emit_en     = 1'b1;
                emit_bit    = tx_data[0];
            end else begin
                state_n = EOP_SE0;
                ones_n  = '0;
                dp_n    = 1'b0;
                dm_n    = 1'b0;
            end
        end

        // NRZI: 0 toggles J/K and breaks the run of ones; 1 holds the line.
        if (emit_en) begin
            if (!emit_bit) begin
                dp_n   = ~d_plus;
                dm_n   = d_plus;
                ones_n = '0;
            end else begin
                ones_n = ones + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Randomized scoreboard bench for usb_tx_encoder: a bit-list reference model predicts line
// states, ack cycles and done cycle per packet; a monitor checks them cycle by cycle.
module tb_usb_tx_encoder;
    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       n_rst = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] tx_data = 8'h00;
    logic       tx_data_valid = 1'b0;
`ifdef USB_TX_ABORT_EN
    logic       tx_abort = 1'b0;
`endif
    logic       tx_byte_ack, tx_busy, tx_done, d_plus, d_minus;

    usb_tx_encoder #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .n_rst(n_rst), .tx_start(tx_start), .tx_data(tx_data),
        .tx_data_valid(tx_data_valid),
`ifdef USB_TX_ABORT_EN
        .tx_abort(tx_abort),
`endif
        .tx_byte_ack(tx_byte_ack), .tx_busy(tx_busy), .tx_done(tx_done),
        .d_plus(d_plus), .d_minus(d_minus)
    );

    always #5 clk = ~clk;

    // Line symbols: J = 2'b10, K = 2'b01, SE0 = 2'b00 as {d_plus, d_minus}.
    typedef struct packed {
        logic [127:0] syms;
        logic [6:0]   nbits;
        logic [2:0]   nack;
        logic [63:0]  acks;
    } pkt_t;

    pkt_t exp_q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    bit   finished = 1'b0;

    function automatic pkt_t model(input int n, input logic [31:0] bytes);
        pkt_t p;
        logic raw[$];
        int   ones = 0;
        int   na = 0;
        logic b;
        logic lvl_j = 1'b1;
        int   k;
        p = '0;
        for (int s = 0; s < 8 + 8 * n; s++) begin
            if (s < 8) begin
                b = (s == 7);
            end else begin
                if ((s - 8) % 8 == 0) begin
                    p.acks[na*16 +: 16] = 16'(raw.size() * CPB - 1);
                    na++;
                end
                b = bytes[s-8];
            end
            raw.push_back(b);
            if (b) ones++; else ones = 0;
            if (ones == 6) begin
                raw.push_back(1'b0);
                ones = 0;
            end
        end
        foreach (raw[i]) begin
            if (!raw[i]) lvl_j = !lvl_j;
            p.syms[2*i +: 2] = lvl_j ? 2'b10 : 2'b01;
        end
        k = raw.size();
        p.syms[2*k +: 2]     = 2'b00;
        p.syms[2*k + 2 +: 2] = 2'b00;
        p.syms[2*k + 4 +: 2] = 2'b10;
        p.nbits = 7'(k + 3);
        p.nack  = 3'(na);
        return p;
    endfunction

    // Monitor / scoreboard
    initial begin
        pkt_t        p;
        int          k;
        int          ai;
        int          want;
        logic [1:0]  e;
        forever begin
            @(negedge clk); #2;
            if (finished) begin
                n_cmp++;
                if (exp_q.size() != 0) begin
                    n_err++;
                    $display("FAIL leftover_packets got %0d want 0", exp_q.size());
                end
                $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
                $finish;
            end
            if (!n_rst) begin
                n_cmp++;
                if ({d_plus, d_minus, tx_busy, tx_byte_ack, tx_done} !== 5'b10000) begin
                    n_err++;
                    $display("FAIL reset_state got %b want 10000",
                             {d_plus, d_minus, tx_busy, tx_byte_ack, tx_done});
                end
            end else if (tx_busy) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL unexpected_start got busy=1 want busy=0");
                    for (int w = 0; w < 2000 && tx_busy && n_rst; w++) begin
                        @(negedge clk); #2;
                    end
                end else begin
                    p  = exp_q.pop_front();
                    k  = 0;
                    ai = 0;
                    while (1) begin
                        if (!n_rst) begin
                            n_cmp++;
                            if ({d_plus, d_minus, tx_busy, tx_byte_ack, tx_done} !== 5'b10000) begin
                                n_err++;
                                $display("FAIL reset_mid_packet got %b want 10000",
                                         {d_plus, d_minus, tx_busy, tx_byte_ack, tx_done});
                            end
                            break;
                        end
                        if (tx_byte_ack) begin
                            n_cmp++;
                            want = (ai < int'(p.nack)) ? int'(p.acks[ai*16 +: 16]) : -1;
                            if (want != k) begin
                                n_err++;
                                $display("FAIL ack_cycle got %0d want %0d", k, want);
                            end
                            ai++;
                        end
                        n_cmp++;
                        if (k == int'(p.nbits) * CPB) begin
                            if ({d_plus, d_minus, tx_busy, tx_done} !== 4'b1001) begin
                                n_err++;
                                $display("FAIL eop_done cycle %0d got %b want 1001", k,
                                         {d_plus, d_minus, tx_busy, tx_done});
                            end
                            break;
                        end
                        e = p.syms[2*(k/CPB) +: 2];
                        if ({d_plus, d_minus, tx_busy, tx_done} !== {e, 2'b10}) begin
                            n_err++;
                            $display("FAIL line cycle %0d got %b want %b", k,
                                     {d_plus, d_minus, tx_busy, tx_done}, {e, 2'b10});
                        end
                        k++;
                        @(negedge clk); #2;
                    end
                    if (n_rst) begin
                        n_cmp++;
                        if (ai != int'(p.nack)) begin
                            n_err++;
                            $display("FAIL ack_count got %0d want %0d", ai, p.nack);
                        end
                    end
                end
            end else begin
                n_cmp++;
                if ({d_plus, d_minus, tx_byte_ack, tx_done} !== 4'b1000) begin
                    n_err++;
                    $display("FAIL idle_state got %b want 1000",
                             {d_plus, d_minus, tx_byte_ack, tx_done});
                end
            end
        end
    end

    task automatic send_pkt(input int n, input logic [31:0] bytes, input int rst_at,
                            input bit start_at_done);
        int idx = 0;
        exp_q.push_back(model(n, bytes));
        @(negedge clk);
        tx_start = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            tx_start      = 1'b0;
            tx_data_valid = (idx < n);
            tx_data       = (idx < n) ? bytes[idx*8 +: 8] : 8'($urandom);
            if (cyc == rst_at) begin
                n_rst = 1'b0;
                break;
            end
            if (tx_done) begin
                tx_start = start_at_done;
                break;
            end
            #1;
            if (tx_byte_ack) idx++;
        end
        @(negedge clk);
        tx_start      = 1'b0;
        tx_data_valid = 1'b0;
        if (!n_rst) begin
            @(negedge clk);
            n_rst = 1'b1;
        end
        repeat (1 + $urandom_range(0, 3)) @(negedge clk);
    endtask

    function automatic logic [7:0] pick_byte();
        case ($urandom_range(0, 4))
            0: return 8'hFF;
            1: return 8'h7E;
            2: return 8'h3F;
            default: return 8'($urandom);
        endcase
    endfunction

    // Stimulus
    initial begin
        logic [31:0] bytes;
        int          n;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            tx_start = 1'($urandom);
        end
        @(negedge clk);
        tx_start = 1'b0;
        n_rst    = 1'b1;
        repeat (2) @(negedge clk);

        send_pkt(1, 32'h0000_00A5, -1, 1'b0);
        send_pkt(1, 32'h0000_00FF, -1, 1'b0);
        send_pkt(2, 32'h0000_7E00, -1, 1'b0);
        send_pkt(0, 32'h0000_0000, -1, 1'b0);
        send_pkt(2, 32'h0000_3CC3, 91, 1'b0);
        send_pkt(1, 32'h0000_0081, -1, 1'b1);
        send_pkt(4, 32'hFFFF_FFFF, -1, 1'b0);
        for (int t = 0; t < 14; t++) begin
            n = $urandom_range(0, 4);
            bytes = {pick_byte(), pick_byte(), pick_byte(), pick_byte()};
            send_pkt(n, bytes, -1, 1'($urandom_range(0, 1)));
        end
        repeat (5) @(negedge clk);
        finished = 1'b1;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
